// File: rtl/ls_reservation_station.sv
// ls_reservation_station
//   In-order reservation station for the load/store unit. Dispatched
//   load/store ops queue in a circular FIFO. Operands that are not yet
//   available wait on a ROB tag and are woken by the result broadcast. Only
//   the head entry may issue, so memory ops reach the LSU in program order.
//   The issue packet is registered.
// Ports
//   in_clk, in_rst              clock, async active-high reset
//   in_dispatch_valid, in_fu_op, in_dst_rob_index,
//   in_val_a/b, in_ready_a/b, in_tag_a/b
//                               dispatch packet (a = address base, b = store data)
//   in_bcast_valid/index/value  result broadcast used for operand wakeup
//   in_fu_ready                 LSU can take an op this cycle
//   in_flush                    squash every queued entry
//   out_full                    no free slot; dispatch must hold
//   out_fu_start, out_fu_op, out_val_a, out_val_b, out_dst_rob_index
//                               registered issue packet (start pulses 1 cycle)

package ls_rs_pkg;
  typedef enum logic [0:0] {
    FU_OP_LDUR = 1'b0,
    FU_OP_STUR = 1'b1
  } fu_op_t;
endpackage

module ls_reservation_station
  import ls_rs_pkg::*;
#(
  parameter int ENTRIES   = 4,
  parameter int ROB_IDX_W = 4,
  parameter int GPR_SIZE  = 64
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_dispatch_valid,
  input  fu_op_t               in_fu_op,
  input  logic [ROB_IDX_W-1:0] in_dst_rob_index,
  input  logic [GPR_SIZE-1:0]  in_val_a,
  input  logic [GPR_SIZE-1:0]  in_val_b,
  input  logic                 in_ready_a,
  input  logic                 in_ready_b,
  input  logic [ROB_IDX_W-1:0] in_tag_a,
  input  logic [ROB_IDX_W-1:0] in_tag_b,
  input  logic                 in_bcast_valid,
  input  logic [ROB_IDX_W-1:0] in_bcast_index,
  input  logic [GPR_SIZE-1:0]  in_bcast_value,
  input  logic                 in_fu_ready,
  input  logic                 in_flush,
  output logic                 out_full,
  output logic                 out_fu_start,
  output fu_op_t               out_fu_op,
  output logic [GPR_SIZE-1:0]  out_val_a,
  output logic [GPR_SIZE-1:0]  out_val_b,
  output logic [ROB_IDX_W-1:0] out_dst_rob_index
);

  localparam int PTR_W = $clog2(ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRIES-1:0]   valid_q, valid_d;
  logic [ENTRIES-1:0]   rdy_a_q, rdy_a_d;
  logic [ENTRIES-1:0]   rdy_b_q, rdy_b_d;
  fu_op_t               op_q    [ENTRIES];
  fu_op_t               op_d    [ENTRIES];
  logic [ROB_IDX_W-1:0] dst_q   [ENTRIES];
  logic [ROB_IDX_W-1:0] dst_d   [ENTRIES];
  logic [ROB_IDX_W-1:0] tag_a_q [ENTRIES];
  logic [ROB_IDX_W-1:0] tag_a_d [ENTRIES];
  logic [ROB_IDX_W-1:0] tag_b_q [ENTRIES];
  logic [ROB_IDX_W-1:0] tag_b_d [ENTRIES];
  logic [GPR_SIZE-1:0]  val_a_q [ENTRIES];
  logic [GPR_SIZE-1:0]  val_a_d [ENTRIES];
  logic [GPR_SIZE-1:0]  val_b_q [ENTRIES];
  logic [GPR_SIZE-1:0]  val_b_d [ENTRIES];

  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 fu_start_q, fu_start_d;
  fu_op_t               fu_op_q, fu_op_d;
  logic [GPR_SIZE-1:0]  fu_val_a_q, fu_val_a_d;
  logic [GPR_SIZE-1:0]  fu_val_b_q, fu_val_b_d;
  logic [ROB_IDX_W-1:0] fu_dst_q, fu_dst_d;

  logic                 full;
  logic                 issue;
  logic                 dispatch;
  logic                 bypass_a;
  logic                 bypass_b;

  // Full comes from the registered count only, so a same-edge issue never
  // makes room for a same-edge dispatch.
  assign full = (count_q == CNT_W'(ENTRIES));

  always_comb begin
    valid_d    = valid_q;
    rdy_a_d    = rdy_a_q;
    rdy_b_d    = rdy_b_q;
    op_d       = op_q;
    dst_d      = dst_q;
    tag_a_d    = tag_a_q;
    tag_b_d    = tag_b_q;
    val_a_d    = val_a_q;
    val_b_d    = val_b_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fu_start_d = 1'b0;
    fu_op_d    = fu_op_q;
    fu_val_a_d = fu_val_a_q;
    fu_val_b_d = fu_val_b_q;
    fu_dst_d   = fu_dst_q;

    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && in_bcast_valid) begin
        if (!rdy_a_q[i] && tag_a_q[i] == in_bcast_index) begin
          rdy_a_d[i] = 1'b1;
          val_a_d[i] = in_bcast_value;
        end
        if (!rdy_b_q[i] && tag_b_q[i] == in_bcast_index) begin
          rdy_b_d[i] = 1'b1;
          val_b_d[i] = in_bcast_value;
        end
      end
    end

    issue    = valid_q[head_q] && rdy_a_q[head_q] && rdy_b_q[head_q] && in_fu_ready;
    dispatch = in_dispatch_valid && !full;
    bypass_a = !in_ready_a && in_bcast_valid && (in_tag_a == in_bcast_index);
    bypass_b = !in_ready_b && in_bcast_valid && (in_tag_b == in_bcast_index);

    if (issue) begin
      fu_start_d      = 1'b1;
      fu_op_d         = op_q[head_q];
      fu_val_a_d      = val_a_q[head_q];
      fu_val_b_d      = val_b_q[head_q];
      fu_dst_d        = dst_q[head_q];
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end

    // Dispatch can only share the head slot when the queue is empty, in
    // which case the head is not issuing, so the two writes never collide.
    if (dispatch) begin
      valid_d[tail_q] = 1'b1;
      op_d[tail_q]    = in_fu_op;
      dst_d[tail_q]   = in_dst_rob_index;
      tag_a_d[tail_q] = in_tag_a;
      tag_b_d[tail_q] = in_tag_b;
      rdy_a_d[tail_q] = in_ready_a || bypass_a;
      rdy_b_d[tail_q] = in_ready_b || bypass_b;
      val_a_d[tail_q] = bypass_a ? in_bcast_value : in_val_a;
      val_b_d[tail_q] = bypass_b ? in_bcast_value : in_val_b;
      tail_d          = tail_q + PTR_W'(1);
    end

    if (dispatch && !issue) begin
      count_d = count_q + CNT_W'(1);
    end else if (!dispatch && issue) begin
      count_d = count_q - CNT_W'(1);
    end

    // Flush wins over everything; the last issued packet values are kept.
    if (in_flush) begin
      valid_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fu_start_d = 1'b0;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      valid_q    <= '0;
      rdy_a_q    <= '0;
      rdy_b_q    <= '0;
      op_q       <= '{default: FU_OP_LDUR};
      dst_q      <= '{default: '0};
      tag_a_q    <= '{default: '0};
      tag_b_q    <= '{default: '0};
      val_a_q    <= '{default: '0};
      val_b_q    <= '{default: '0};
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fu_start_q <= 1'b0;
      fu_op_q    <= FU_OP_LDUR;
      fu_val_a_q <= '0;
      fu_val_b_q <= '0;
      fu_dst_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      rdy_a_q    <= rdy_a_d;
      rdy_b_q    <= rdy_b_d;
      op_q       <= op_d;
      dst_q      <= dst_d;
      tag_a_q    <= tag_a_d;
      tag_b_q    <= tag_b_d;
      val_a_q    <= val_a_d;
      val_b_q    <= val_b_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fu_start_q <= fu_start_d;
      fu_op_q    <= fu_op_d;
      fu_val_a_q <= fu_val_a_d;
      fu_val_b_q <= fu_val_b_d;
      fu_dst_q   <= fu_dst_d;
    end
  end

  assign out_full          = full;
  assign out_fu_start      = fu_start_q;
  assign out_fu_op         = fu_op_q;
  assign out_val_a         = fu_val_a_q;
  assign out_val_b         = fu_val_b_q;
  assign out_dst_rob_index = fu_dst_q;

endmodule

// File: tb/tb_ls_reservation_station.sv
// tb_ls_reservation_station
//   Directed-vector bench for ls_reservation_station with default parameters.
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.

module tb_ls_reservation_station;
  import ls_rs_pkg::*;

  logic        clk;
  logic        rst;
  logic        dispatch_valid;
  fu_op_t      fu_op;
  logic [3:0]  dst_rob_index;
  logic [63:0] val_a;
  logic [63:0] val_b;
  logic        ready_a;
  logic        ready_b;
  logic [3:0]  tag_a;
  logic [3:0]  tag_b;
  logic        bcast_valid;
  logic [3:0]  bcast_index;
  logic [63:0] bcast_value;
  logic        fu_ready;
  logic        flush;
  logic        full;
  logic        fu_start;
  fu_op_t      out_op;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [3:0]  out_dst;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  ls_reservation_station #(
    .ENTRIES  (4),
    .ROB_IDX_W(4),
    .GPR_SIZE (64)
  ) dut (
    .in_clk           (clk),
    .in_rst           (rst),
    .in_dispatch_valid(dispatch_valid),
    .in_fu_op         (fu_op),
    .in_dst_rob_index (dst_rob_index),
    .in_val_a         (val_a),
    .in_val_b         (val_b),
    .in_ready_a       (ready_a),
    .in_ready_b       (ready_b),
    .in_tag_a         (tag_a),
    .in_tag_b         (tag_b),
    .in_bcast_valid   (bcast_valid),
    .in_bcast_index   (bcast_index),
    .in_bcast_value   (bcast_value),
    .in_fu_ready      (fu_ready),
    .in_flush         (flush),
    .out_full         (full),
    .out_fu_start     (fu_start),
    .out_fu_op        (out_op),
    .out_val_a        (out_a),
    .out_val_b        (out_b),
    .out_dst_rob_index(out_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input fu_op_t op, input logic [3:0] dst,
                      input logic [63:0] a, input logic ra, input logic [3:0] ta,
                      input logic [63:0] b, input logic rb, input logic [3:0] tb);
    dispatch_valid = 1'b1;
    fu_op          = op;
    dst_rob_index  = dst;
    val_a          = a;
    ready_a        = ra;
    tag_a          = ta;
    val_b          = b;
    ready_b        = rb;
    tag_b          = tb;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    bcast_valid    = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic bcast(input logic [3:0] idx, input logic [63:0] v);
    bcast_valid = 1'b1;
    bcast_index = idx;
    bcast_value = v;
  endtask

  task automatic check_start(input string tag, input logic [3:0] dst, input logic [63:0] a);
    check({tag, ".start"}, fu_start, 1'b1);
    check({tag, ".dst"}, out_dst, dst);
    check({tag, ".val_a"}, out_a, a);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    disp(FU_OP_LDUR, 0, 0, 1, 0, 0, 1, 0);
    dispatch_valid = 1'b0;
    bcast_index = '0;
    bcast_value = '0;
    fu_ready = 1'b1;
    #1;
    check("rst.full", full, 0);
    check("rst.start", fu_start, 0);
    check("rst.val_a", out_a, 0);
    check("rst.val_b", out_b, 0);
    check("rst.dst", out_dst, 0);
    check("rst.op", out_op, FU_OP_LDUR);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Ready LDUR: start two edges after dispatch.
    disp(FU_OP_LDUR, 3, 64'h100, 1, 0, 0, 1, 0);
    tick();
    idle();
    check("lat.early", fu_start, 0);
    tick();
    check_start("lat", 3, 64'h100);
    check("lat.op", out_op, FU_OP_LDUR);
    tick();
    check("lat.pulse", fu_start, 0);
    check("lat.hold", out_a, 64'h100);

    // STUR waiting on tag 5, woken two cycles later.
    disp(FU_OP_STUR, 4, 64'h0, 0, 5, 64'h77, 1, 0);
    tick();
    idle();
    tick();
    check("wake.wait", fu_start, 0);
    bcast(5, 64'h40);
    tick();
    idle();
    check("wake.bedge", fu_start, 0);
    tick();
    check_start("wake", 4, 64'h40);
    check("wake.val_b", out_b, 64'h77);
    check("wake.op", out_op, FU_OP_STUR);
    tick();
    check("wake.pulse", fu_start, 0);

    // In-order: blocked head holds back a ready second entry.
    disp(FU_OP_LDUR, 5, 64'h0, 0, 2, 64'h1, 1, 0);
    tick();
    disp(FU_OP_LDUR, 6, 64'h200, 1, 0, 64'h0, 1, 0);
    tick();
    idle();
    bcast(9, 64'hdead);
    tick();
    idle();
    check("order.block0", fu_start, 0);
    tick();
    check("order.block1", fu_start, 0);
    bcast(2, 64'h300);
    tick();
    idle();
    check("order.bedge", fu_start, 0);
    tick();
    check_start("order.first", 5, 64'h300);
    tick();
    check_start("order.second", 6, 64'h200);
    tick();
    check("order.done", fu_start, 0);

    // Fill with LSU stalled, hold fifth dispatch, then drain with wrap.
    fu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("fill.notfull", full, 0);
      disp(FU_OP_LDUR, 4'(8 + i), 64'(8 + i), 1, 0, 64'h0, 1, 0);
      tick();
    end
    check("fill.full", full, 1);
    disp(FU_OP_LDUR, 12, 64'd12, 1, 0, 64'h0, 1, 0);
    tick();
    check("fill.held", full, 1);
    check("fill.nostart", fu_start, 0);
    fu_ready = 1'b1;
    tick();
    check_start("drain.8", 8, 64'd8);
    check("drain.full", full, 0);
    tick();
    idle();
    check_start("drain.9", 9, 64'd9);
    tick();
    check_start("drain.10", 10, 64'd10);
    tick();
    check_start("drain.11", 11, 64'd11);
    tick();
    check_start("drain.12", 12, 64'd12);
    tick();
    check("drain.end", fu_start, 0);
    check("drain.empty", full, 0);

    // Same-edge bypass of a broadcast into a dispatching operand.
    disp(FU_OP_LDUR, 13, 64'h0, 0, 7, 64'h0, 1, 0);
    bcast(7, 64'd9);
    tick();
    idle();
    tick();
    check_start("bypass", 13, 64'd9);
    tick();

    // Flush with three pending and a simultaneous dispatch.
    fu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(FU_OP_STUR, 4'(1 + i), 64'hA0 + 64'(i), 1, 0, 64'h0, 1, 0);
      tick();
    end
    disp(FU_OP_LDUR, 14, 64'hEE, 1, 0, 64'h0, 1, 0);
    flush = 1'b1;
    tick();
    idle();
    fu_ready = 1'b1;
    check("flush.full", full, 0);
    check("flush.start", fu_start, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush.quiet", fu_start, 0);
    end
    // Count must restart at zero: exactly four dispatches to reach full.
    fu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(FU_OP_LDUR, 4'(1 + i), 64'h50 + 64'(i), 1, 0, 64'h0, 1, 0);
      tick();
      check("refill.full", full, (i == 3) ? 1'b1 : 1'b0);
    end
    idle();
    fu_ready = 1'b1;
    tick();
    check_start("refill.head", 1, 64'h50);

    // Asynchronous reset mid-stream.
    #2;
    rst = 1'b1;
    #1;
    check("arst.start", fu_start, 0);
    check("arst.val_a", out_a, 0);
    check("arst.dst", out_dst, 0);
    check("arst.full", full, 0);
    check("arst.op", out_op, FU_OP_LDUR);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("arst.quiet", fu_start, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
